// File: rtl/pp_row_accumulator_40x40.sv
// Sequential row accumulator for the 40x40 AND partial-product matrix.
// Each cycle it adds ROWS_PER_CYCLE pre-shifted 80-bit rows and returns the product over valid/ready.
module pp_row_accumulator_40x40 #(
  parameter  int ROWS_PER_CYCLE = 4,
  localparam int NUM_ROWS       = 40,
  localparam int ROW_W          = 80,
  localparam int MAT_W          = NUM_ROWS * ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAT_W-1:0] pp_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ROW_W-1:0] prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int GROUPS  = NUM_ROWS / ROWS_PER_CYCLE;
  localparam int GROUP_W = ROWS_PER_CYCLE * ROW_W;
  localparam int IDX_W   = $clog2(NUM_ROWS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - ROWS_PER_CYCLE);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(ROWS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAT_W-1:0]   matrix_q;
  logic [MAT_W-1:0]   matrix_shr;
  logic [ROW_W-1:0]   acc_q;
  logic [ROW_W-1:0]   prod_q;
  logic [ROW_W-1:0]   group_sum;
  logic [ROW_W-1:0]   acc_sum;
  logic [IDX_W-1:0]   idx_q;
  logic               accept;
  logic               last_group;

  // The current group always sits in the low GROUP_W bits: the matrix register
  // shifts down by one group per ACCUM cycle instead of muxing by idx.
  generate
    if (GROUPS > 1) begin : g_shift
      assign matrix_shr = {{GROUP_W{1'b0}}, matrix_q[MAT_W-1:GROUP_W]};
    end else begin : g_single
      assign matrix_shr = '0;
    end
  endgenerate

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    group_sum = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      group_sum = group_sum + matrix_q[j*ROW_W +: ROW_W];
    end
  end

  assign acc_sum    = acc_q + group_sum;
  assign last_group = (idx_q == LAST_IDX);
  assign accept     = in_valid && in_ready;

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_group) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? ACCUM : IDLE;
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the wide matrix register is reset too, so no stale operand survives
  // a reset and the block powers up in a fully defined state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      prod_q   <= '0;
    end else if (accept) begin
      matrix_q <= pp_in;
      acc_q    <= '0;
      idx_q    <= '0;
    end else if (state_q == ACCUM) begin
      matrix_q <= matrix_shr;
      acc_q    <= acc_sum;
      idx_q    <= idx_q + IDX_STEP;
      if (last_group) prod_q <= acc_sum;
    end
  end

  assign prod = prod_q;

endmodule

// File: tb/tb_pp_row_accumulator_40x40.sv
// Directed bench for pp_row_accumulator_40x40: latency, handshake, back-to-back,
// backpressure, reset mid-operation, and a ROWS_PER_CYCLE sweep (1, 8, 40).
module tb_pp_row_accumulator_40x40;

  localparam int MAT_W = 3200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [MAT_W-1:0] pp_in;
  logic             in_valid;
  logic             in_ready;
  logic [79:0]      prod;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  logic [MAT_W-1:0] sw_pp;
  logic             sw_valid;
  logic             sw_in_ready  [3];
  logic             sw_out_valid [3];
  logic             sw_busy      [3];
  logic [79:0]      sw_prod      [3];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pp_row_accumulator_40x40 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp_in     (pp_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int R = (g == 0) ? 1 : (g == 1) ? 8 : 40;
    pp_row_accumulator_40x40 #(.ROWS_PER_CYCLE(R)) sdut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pp_in     (sw_pp),
      .in_valid  (sw_valid),
      .in_ready  (sw_in_ready[g]),
      .prod      (sw_prod[g]),
      .out_valid (sw_out_valid[g]),
      .out_ready (1'b1),
      .busy      (sw_busy[g])
    );
  end

  function automatic logic [MAT_W-1:0] build_pp(input logic [39:0] a, input logic [39:0] b);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < 40; k++) begin
      if (b[k]) m[k*80 +: 80] = {40'b0, a} << k;
    end
    return m;
  endfunction

  // Counts rising edges after the accepting edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    pp_in     = build_pp(40'd5, 40'd5);
    sw_valid  = 1'b0;
    sw_pp     = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_flags: got in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    tests_run++;
    if (prod !== 80'd0) begin
      tests_failed++;
      $display("FAIL reset_prod: got %h required 0", prod);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b required 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic run_one(input string name, input logic [39:0] a, input logic [39:0] b,
                         input logic [79:0] exp);
    int lat;
    @(negedge clk);
    pp_in     = build_pp(a, b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_in_ready: got %b required 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pp_in    = '1;
    tests_run++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL %s_accum_flags: got busy/in_ready/out_valid=%b required 100", name, {busy, in_ready, out_valid});
    end
    wait_out(lat);
    tests_run++;
    if (lat !== 10) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d required 10", name, lat);
    end
    tests_run++;
    if (prod !== exp) begin
      tests_failed++;
      $display("FAIL %s_prod: got %h required %h", name, prod, exp);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      tests_failed++;
      $display("FAIL %s_back_to_idle: got out_valid/in_ready/busy=%b required 010", name, {out_valid, in_ready, busy});
    end
    tests_run++;
    if (prod !== exp) begin
      tests_failed++;
      $display("FAIL %s_prod_retained: got %h required %h", name, prod, exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    pp_in     = build_pp(40'd3, 40'd5);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pp_in = build_pp(40'd7, 40'd11);
    wait_out(lat);
    tests_run++;
    if (lat !== 10 || prod !== 80'd15) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d prod=%h required lat=10 prod=f", lat, prod);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_in_ready_done: got %b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    pp_in     = '1;
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid, busy, in_ready} !== 3'b010) begin
      tests_failed++;
      $display("FAIL b2b_no_bubble: got out_valid/busy/in_ready=%b required 010", {out_valid, busy, in_ready});
    end
    wait_out(lat);
    tests_run++;
    if (lat !== 10 || prod !== 80'd77) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat=%0d prod=%h required lat=10 prod=4d", lat, prod);
    end
  endtask

  // Continues from test_back_to_back: DONE holding 77 with out_ready low.
  task automatic test_backpressure();
    int lat;
    pp_in    = build_pp(40'd4, 40'd6);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({out_valid, in_ready} !== 2'b10 || prod !== 80'd77) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got out_valid/in_ready=%b prod=%h required 10 prod=4d",
                 i, {out_valid, in_ready}, prod);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    pp_in    = '1;
    tests_run++;
    if ({out_valid, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_accept_on_release: got out_valid/busy=%b required 01", {out_valid, busy});
    end
    wait_out(lat);
    tests_run++;
    if (lat !== 10 || prod !== 80'd24) begin
      tests_failed++;
      $display("FAIL bp_next_result: got lat=%0d prod=%h required lat=10 prod=18", lat, prod);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    @(negedge clk);
    pp_in     = build_pp(40'd123, 40'd456);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({busy, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got busy/out_valid=%b required 10", {busy, out_valid});
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, busy} !== 3'b010 || prod !== 80'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_immediate: got out_valid/in_ready/busy=%b prod=%h required 010 prod=0",
               {out_valid, in_ready, busy}, prod);
    end
    seen_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_pulse: got out_valid pulse=%b required 0", seen_valid);
    end
    run_one("after_reset", 40'd2, 40'd9, 80'd18);
  endtask

  task automatic test_sweep(input int round);
    logic [63:0] ra, rb;
    logic [39:0] a, b;
    logic [79:0] exp;
    int          lat [3];
    logic [79:0] got [3];
    int          exp_lat [3];
    exp_lat = '{40, 5, 1};
    ra  = {$urandom, $urandom};
    rb  = {$urandom, $urandom};
    a   = ra[39:0];
    b   = rb[39:0];
    exp = {40'b0, a} * {40'b0, b};
    @(negedge clk);
    sw_pp    = build_pp(a, b);
    sw_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_valid = 1'b0;
    sw_pp    = '1;
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      got[i] = '0;
    end
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (sw_out_valid[i] && lat[i] < 0) begin
          lat[i] = c;
          got[i] = sw_prod[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (lat[i] !== exp_lat[i]) begin
        tests_failed++;
        $display("FAIL sweep%0d_latency_%0d: got %0d required %0d", round, i, lat[i], exp_lat[i]);
      end
      tests_run++;
      if (got[i] !== exp) begin
        tests_failed++;
        $display("FAIL sweep%0d_prod_%0d: a=%h b=%h got %h required %h", round, i, a, b, got[i], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    run_one("one_by_one", 40'd1, 40'd1, 80'h0000_0000_0000_0000_0001);
    run_one("max_by_max", 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 80'hFFFF_FFFF_FE00_0000_0001);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep(0);
    test_sweep(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
